event_blinker: RTL and testbench

- Output-side counterpart to the debounced button-event path.
- Accepts single-cycle event pulses (e.g. `next_falling`) and turns each one into a clean, human-visible pulse on a physical pin (LED or buzzer).
- Each pulse has a guaranteed ON time and a guaranteed OFF gap.
- Events that arrive while a pulse is in progress are queued in a saturating counter, so no two events merge into one blink.

---
 rtl/blink_pkg.sv | 28 ++
 rtl/event_blinker.sv | 105 ++++++++++
 tb/tb_event_blinker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the event-to-visible-pulse blinker.
package blink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ON   = ST_ON,
    S_GAP  = ST_GAP
  } blink_state_t;

  // Number of bits needed to hold values 0..v-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_blinker.sv
// Stretches single-cycle events into ON/GAP pulses on a pad, queueing
// events that arrive while a pulse is in progress.
module event_blinker
  import blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned PEND_W     = 3,
  parameter bit          OUT_POL    = 1'b1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              evt_in,
  output logic              out_pin,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int unsigned CW = clog2(umax(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0]     ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic              LVL_ACT  = OUT_POL;
  localparam logic              LVL_IDL  = !OUT_POL;

  blink_state_t  state;
  logic [CW-1:0] cnt;

  logic pend_nz;
  logic gap_last;
  logic take_direct;
  logic enq;
  logic deq;

  // An event is consumed directly when it can start a pulse right away;
  // otherwise it joins the queue.
  always_comb begin
    pend_nz     = (pend_cnt != '0);
    gap_last    = (state == S_GAP) && (cnt == '0);
    take_direct = (state == S_IDLE) || (gap_last && !pend_nz);
    enq         = evt_in && !take_direct;
    deq         = gap_last && pend_nz;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pend_cnt <= '0;
      out_pin  <= LVL_IDL;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          if (evt_in) begin
            state   <= S_ON;
            cnt     <= ON_LOAD;
            out_pin <= LVL_ACT;
            busy    <= 1'b1;
          end
        end
        S_ON: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state   <= S_GAP;
            cnt     <= GAP_LOAD;
            out_pin <= LVL_IDL;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (pend_nz || evt_in) begin
            state   <= S_ON;
            cnt     <= ON_LOAD;
            out_pin <= LVL_ACT;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          out_pin <= LVL_IDL;
          busy    <= 1'b0;
        end
      endcase

      // Simultaneous enq/deq leaves the count unchanged, so no drop occurs.
      if (enq && !deq) begin
        if (pend_cnt != PEND_MAX) pend_cnt <= pend_cnt + PEND_W'(1);
        else                      overflow <= 1'b1;
      end else if (deq && !enq) begin
        pend_cnt <= pend_cnt - PEND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON=4, GAP=3, PEND_W=2 in both polarities.
module tb_event_blinker;

  logic       clk;
  logic       nRst;
  logic       evt_in;
  logic       out_p, busy_p, ovf_p;
  logic [1:0] pend_p;
  logic       out_n, busy_n, ovf_n;
  logic [1:0] pend_n;

  int checks;
  int errors;

  logic       obs_out  [0:63];
  logic       obs_outn [0:63];
  logic       obs_busy [0:63];
  logic [1:0] obs_pend [0:63];
  logic       obs_ovf  [0:63];

  event_blinker #(.ON_CYCLES(4), .GAP_CYCLES(3), .PEND_W(2), .OUT_POL(1'b1)) dut_p (
    .clk(clk), .nRst(nRst), .evt_in(evt_in),
    .out_pin(out_p), .busy(busy_p), .pend_cnt(pend_p), .overflow(ovf_p)
  );

  event_blinker #(.ON_CYCLES(4), .GAP_CYCLES(3), .PEND_W(2), .OUT_POL(1'b0)) dut_n (
    .clk(clk), .nRst(nRst), .evt_in(evt_in),
    .out_pin(out_n), .busy(busy_n), .pend_cnt(pend_n), .overflow(ovf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives ev[k] before edge k and records outputs just after edge k.
  task automatic run_seq(input int n, input logic [63:0] ev);
    for (int k = 0; k < n; k++) begin
      evt_in = ev[k];
      step();
      obs_out[k]  = out_p;
      obs_outn[k] = out_n;
      obs_busy[k] = busy_p;
      obs_pend[k] = pend_p;
      obs_ovf[k]  = ovf_p;
    end
    evt_in = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    evt_in = 1'b0;
    step();
    step();
    checks++;
    if (out_p !== 1'b0 || out_n !== 1'b1 || busy_p !== 1'b0 || pend_p !== 2'd0 || ovf_p !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%b out_n=%b busy=%b pend=%0d ovf=%b, required 0 1 0 0 0",
               out_p, out_n, busy_p, pend_p, ovf_p);
    end
    nRst = 1'b1;
    step();
  endtask

  // Generic blink-train check: nb blinks starting at edge 0, period 7.
  task automatic test_single();
    logic eo, eb;
    run_seq(10, 64'h1);
    for (int k = 0; k < 10; k++) begin
      eo = (k < 7) && ((k % 7) < 4);
      eb = (k < 7);
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== eb ||
          obs_pend[k] !== 2'd0 || obs_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL single k=%0d: out=%b out_n=%b busy=%b pend=%0d ovf=%b, required %b %b %b 0 0",
                 k, obs_out[k], obs_outn[k], obs_busy[k], obs_pend[k], obs_ovf[k], eo, !eo, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic eo, eb;
    logic [1:0] ep;
    run_seq(24, 64'h7);
    for (int k = 0; k < 24; k++) begin
      eo = (k < 21) && ((k % 7) < 4);
      eb = (k < 21);
      ep = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 7) ? 2'd2 : (k < 14) ? 2'd1 : 2'd0;
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== eb ||
          obs_pend[k] !== ep || obs_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back k=%0d: out=%b busy=%b pend=%0d ovf=%b, required %b %b %0d 0",
                 k, obs_out[k], obs_busy[k], obs_pend[k], obs_ovf[k], eo, eb, ep);
      end
    end
  endtask

  task automatic test_overflow();
    logic eo, eb, ef;
    logic [1:0] ep;
    run_seq(31, 64'h1F);
    for (int k = 0; k < 31; k++) begin
      eo = (k < 28) && ((k % 7) < 4);
      eb = (k < 28);
      ef = (k == 4);
      ep = (k < 4) ? 2'(k) : (k < 7) ? 2'd3 : (k < 14) ? 2'd2 : (k < 21) ? 2'd1 : 2'd0;
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== eb ||
          obs_pend[k] !== ep || obs_ovf[k] !== ef) begin
        errors++;
        $display("FAIL overflow k=%0d: out=%b busy=%b pend=%0d ovf=%b, required %b %b %0d %b",
                 k, obs_out[k], obs_busy[k], obs_pend[k], obs_ovf[k], eo, eb, ep, ef);
      end
    end
  endtask

  task automatic test_gap_restart();
    logic eo, eb;
    run_seq(17, 64'h81);
    for (int k = 0; k < 17; k++) begin
      eo = (k < 14) && ((k % 7) < 4);
      eb = (k < 14);
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== eb ||
          obs_pend[k] !== 2'd0 || obs_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL gap_restart k=%0d: out=%b busy=%b pend=%0d ovf=%b, required %b %b 0 0",
                 k, obs_out[k], obs_busy[k], obs_pend[k], obs_ovf[k], eo, eb);
      end
    end
  endtask

  task automatic test_enq_deq();
    logic eo, eb;
    logic [1:0] ep;
    run_seq(38, 64'h8F);
    for (int k = 0; k < 38; k++) begin
      eo = (k < 35) && ((k % 7) < 4);
      eb = (k < 35);
      ep = (k < 3) ? 2'(k) : (k < 14) ? 2'd3 : (k < 21) ? 2'd2 : (k < 28) ? 2'd1 : 2'd0;
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== eb ||
          obs_pend[k] !== ep || obs_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL enq_deq k=%0d: out=%b busy=%b pend=%0d ovf=%b, required %b %b %0d 0",
                 k, obs_out[k], obs_busy[k], obs_pend[k], obs_ovf[k], eo, eb, ep);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic eo;
    run_seq(3, 64'h7);
    checks++;
    if (pend_p !== 2'd2 || out_p !== 1'b1 || out_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pre: pend=%0d out=%b out_n=%b, required 2 1 0", pend_p, out_p, out_n);
    end
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    checks++;
    if (out_p !== 1'b0 || out_n !== 1'b1 || busy_p !== 1'b0 || busy_n !== 1'b0 ||
        pend_p !== 2'd0 || pend_n !== 2'd0 || ovf_p !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out=%b out_n=%b busy=%b pend=%0d ovf=%b, required 0 1 0 0 0",
               out_p, out_n, busy_p, pend_p, ovf_p);
    end
    // Nothing may resume from the discarded queue.
    run_seq(12, 64'h0);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (obs_out[k] !== 1'b0 || obs_outn[k] !== 1'b1 || obs_busy[k] !== 1'b0 || obs_pend[k] !== 2'd0) begin
        errors++;
        $display("FAIL mid_reset_idle k=%0d: out=%b out_n=%b busy=%b pend=%0d, required 0 1 0 0",
                 k, obs_out[k], obs_outn[k], obs_busy[k], obs_pend[k]);
      end
    end
    run_seq(9, 64'h1);
    for (int k = 0; k < 9; k++) begin
      eo = (k < 4);
      checks++;
      if (obs_out[k] !== eo || obs_outn[k] !== !eo || obs_busy[k] !== (k < 7)) begin
        errors++;
        $display("FAIL mid_reset_blink k=%0d: out=%b out_n=%b busy=%b, required %b %b %b",
                 k, obs_out[k], obs_outn[k], obs_busy[k], eo, !eo, (k < 7));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRst   = 1'b0;
    evt_in = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_restart();
    test_enq_deq();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
